// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline stall/flush sequencer: controller state
// encoding and register-index constants.
package pipe_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        PC_RUN      = 2'd0,
        PC_DIV_WAIT = 2'd1,
        PC_EXC_HOLD = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// pipe_hazard_cmp
// Combinational source/destination comparator. Reports whether the D-stage
// instruction reads a register that a later stage is about to write.
// Ports:
//   rs, rt          : D-stage source register indices
//   use_rs, use_rt  : the D instruction actually reads rs / rt
//   dst             : destination register index of the later stage
//   dst_valid       : the later stage really writes dst
//   match           : a used source equals a live, non-zero destination
module pipe_hazard_cmp
    import pipe_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs,
    input  logic [REG_IDX_W-1:0] rt,
    input  logic                 use_rs,
    input  logic                 use_rt,
    input  logic [REG_IDX_W-1:0] dst,
    input  logic                 dst_valid,
    output logic                 match
);

    // $zero is never a real dependency, so it is filtered here once.
    assign match = dst_valid && (dst != REG_ZERO) &&
                   ((use_rs && (rs == dst)) || (use_rt && (rt == dst)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Resolves load-use
// and branch-operand hazards, holds the pipe during multi-cycle divides and
// defers exception flushes until memory stalls clear.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   i_stall, d_stall         : instruction / data memory not ready
//   rsD, rtD, use_rsD/rtD    : D-stage sources and their use bits
//   branchD                  : D instruction compares operands in D
//   reg_writeE, mem_readE,
//   write_regE               : E-stage destination info
//   mem_readM, write_regM    : M-stage load destination info
//   div_startE, div_readyE   : divider in E / divider result valid
//   exc_M                    : exception or interrupt commits in M
//   stallF..stallW           : hold pipeline registers
//   flushD..flushW           : insert bubbles
//   div_abort                : kill the in-flight divide (combinational)
//   stall_cnt                : saturating count of cycles with stallF=1
//
// state        | meaning
// -------------+--------------------------------------------------------
// PC_RUN       | normal flow; hazards and one-shot exceptions handled here
// PC_DIV_WAIT  | multi-cycle divide in E, waiting for div_readyE
// PC_EXC_HOLD  | exception latched while memory stalled; flush on release
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_stall,
    input  logic                 d_stall,
    input  logic [REG_IDX_W-1:0] rsD,
    input  logic [REG_IDX_W-1:0] rtD,
    input  logic                 use_rsD,
    input  logic                 use_rtD,
    input  logic                 branchD,
    input  logic                 reg_writeE,
    input  logic                 mem_readE,
    input  logic [REG_IDX_W-1:0] write_regE,
    input  logic                 mem_readM,
    input  logic [REG_IDX_W-1:0] write_regM,
    input  logic                 div_startE,
    input  logic                 div_readyE,
    input  logic                 exc_M,
    output logic                 stallF,
    output logic                 stallD,
    output logic                 stallE,
    output logic                 stallM,
    output logic                 stallW,
    output logic                 flushD,
    output logic                 flushE,
    output logic                 flushM,
    output logic                 flushW,
    output logic                 div_abort,
    output logic [CNT_W-1:0]     stall_cnt
);

    pc_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_stall;
    logic match_e, match_m;
    logic lu, brh, haz;
    logic flush_fire, div_wait;
    logic [4:0] stall_v;   // {F, D, E, M, W}
    logic [3:0] flush_v;   // {D, E, M, W}

    assign mem_stall = i_stall | d_stall;

    pipe_hazard_cmp u_cmp_e (
        .rs        (rsD),
        .rt        (rtD),
        .use_rs    (use_rsD),
        .use_rt    (use_rtD),
        .dst       (write_regE),
        .dst_valid (reg_writeE),
        .match     (match_e)
    );

    pipe_hazard_cmp u_cmp_m (
        .rs        (rsD),
        .rt        (rtD),
        .use_rs    (use_rsD),
        .use_rt    (use_rtD),
        .dst       (write_regM),
        .dst_valid (mem_readM),
        .match     (match_m)
    );

    // A load in E cannot forward to D at all; a branch comparing in D also
    // has to wait on ALU results in E and on loads still in M.
    assign lu  = mem_readE & match_e;
    assign brh = branchD & (match_e | match_m);
    assign haz = lu | brh;

    always_comb begin
        state_d    = state_q;
        flush_fire = 1'b0;
        div_abort  = 1'b0;
        case (state_q)
            PC_RUN: begin
                if (exc_M) begin
                    if (mem_stall) state_d = PC_EXC_HOLD;
                    else           flush_fire = 1'b1;
                end else if (div_startE && !div_readyE) begin
                    state_d = PC_DIV_WAIT;
                end
            end
            PC_DIV_WAIT: begin
                if (exc_M) begin
                    div_abort = 1'b1;
                    if (mem_stall) begin
                        state_d = PC_EXC_HOLD;
                    end else begin
                        flush_fire = 1'b1;
                        state_d    = PC_RUN;
                    end
                end else if (div_readyE) begin
                    state_d = PC_RUN;
                end
            end
            PC_EXC_HOLD: begin
                if (!mem_stall) begin
                    flush_fire = 1'b1;
                    state_d    = PC_RUN;
                end
            end
            default: state_d = PC_RUN;
        endcase
    end

    assign div_wait = (((state_q == PC_RUN) && div_startE) || (state_q == PC_DIV_WAIT))
                      && !div_readyE;

    always_comb begin
        stall_v = 5'b00000;
        flush_v = 4'b0000;
        if (flush_fire) begin
            flush_v = 4'b1111;
        end else if (mem_stall || (state_q == PC_EXC_HOLD)) begin
            stall_v = 5'b11111;
        end else if (div_wait) begin
            // Divide occupies E; M gets a bubble while F/D/E hold.
            stall_v = 5'b11100;
            flush_v = 4'b0010;
        end else if (haz) begin
            stall_v = 5'b11000;
            flush_v = 4'b0100;
        end
    end

    assign {stallF, stallD, stallE, stallM, stallW} = stall_v;
    assign {flushD, flushE, flushM, flushW}         = flush_v;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PC_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic       i_stall;
        logic       d_stall;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       branch;
        logic       reg_writeE;
        logic       mem_readE;
        logic [4:0] write_regE;
        logic       mem_readM;
        logic [4:0] write_regM;
        logic       div_start;
        logic       div_ready;
        logic       exc;
    } vec_t;

    typedef struct packed {
        logic [4:0]    stall;
        logic [3:0]    flush;
        logic          abort;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic i_stall, d_stall;
    logic [4:0] rsD, rtD, write_regE, write_regM;
    logic use_rsD, use_rtD, branchD, reg_writeE, mem_readE, mem_readM;
    logic div_startE, div_readyE, exc_M;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushD, flushE, flushM, flushW, div_abort;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_stall(i_stall), .d_stall(d_stall),
        .rsD(rsD), .rtD(rtD), .use_rsD(use_rsD), .use_rtD(use_rtD),
        .branchD(branchD),
        .reg_writeE(reg_writeE), .mem_readE(mem_readE), .write_regE(write_regE),
        .mem_readM(mem_readM), .write_regM(write_regM),
        .div_startE(div_startE), .div_readyE(div_readyE), .exc_M(exc_M),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .div_abort(div_abort), .stall_cnt(stall_cnt)
    );

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vec_idx = 0;
    logic [CW-1:0] exp_cnt = '0;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_ALL  = 5'b11111;
    localparam logic [4:0] S_DIV  = 5'b11100;
    localparam logic [4:0] S_HAZ  = 5'b11000;
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_ALL  = 4'b1111;
    localparam logic [3:0] F_DIV  = 4'b0010;
    localparam logic [3:0] F_HAZ  = 4'b0100;

    task automatic apply(input vec_t v);
        i_stall    = v.i_stall;    d_stall    = v.d_stall;
        rsD        = v.rs;         rtD        = v.rt;
        use_rsD    = v.use_rs;     use_rtD    = v.use_rt;
        branchD    = v.branch;
        reg_writeE = v.reg_writeE; mem_readE  = v.mem_readE;
        write_regE = v.write_regE;
        mem_readM  = v.mem_readM;  write_regM = v.write_regM;
        div_startE = v.div_start;  div_readyE = v.div_ready;
        exc_M      = v.exc;
    endtask

    // Drive one cycle and queue the hand-computed response. The expected
    // counter is the saturating count of expected stallF cycles so far.
    task automatic cyc(input vec_t v, input logic [4:0] es, input logic [3:0] ef,
                       input logic ea);
        exp_t e;
        apply(v);
        e.stall = es; e.flush = ef; e.abort = ea; e.cnt = exp_cnt;
        exp_q.push_back(e);
        if (es[4] && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        exp_t e;
        rst = 1'b1;
        apply('0);
        exp_cnt = '0;
        e.stall = S_NONE; e.flush = F_NONE; e.abort = 1'b0; e.cnt = '0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: every cycle presents an output; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] gs;
            logic [3:0] gf;
            e  = exp_q.pop_front();
            gs = {stallF, stallD, stallE, stallM, stallW};
            gf = {flushD, flushE, flushM, flushW};
            n_tests++;
            if (gs !== e.stall || gf !== e.flush || div_abort !== e.abort ||
                stall_cnt !== e.cnt) begin
                n_fail++;
                $display("FAIL outs vec%0d: got stall=%b flush=%b abort=%b cnt=%0d, want stall=%b flush=%b abort=%b cnt=%0d",
                         vec_idx, gs, gf, div_abort, stall_cnt,
                         e.stall, e.flush, e.abort, e.cnt);
            end
            vec_idx++;
        end
    end

    initial begin
        vec_t z, v;
        int   guard;
        z = '0;
        rst = 1'b1;
        apply(z);
        @(posedge clk); #1;
        do_reset();

        cyc(z, S_NONE, F_NONE, 1'b0);

        // Load-use on rs
        v = z; v.mem_readE = 1; v.reg_writeE = 1; v.write_regE = 5'd8;
        v.rs = 5'd8; v.use_rs = 1;
        cyc(v, S_HAZ, F_HAZ, 1'b0);
        cyc(z, S_NONE, F_NONE, 1'b0);
        v.write_regE = 5'd0;
        cyc(v, S_NONE, F_NONE, 1'b0);
        // Load-use where the match is on an unused source
        v = z; v.mem_readE = 1; v.reg_writeE = 1; v.write_regE = 5'd8;
        v.rt = 5'd8; v.use_rt = 0;
        cyc(v, S_NONE, F_NONE, 1'b0);

        // Branch on a load still in M
        v = z; v.branch = 1; v.rt = 5'd9; v.use_rt = 1; v.mem_readM = 1; v.write_regM = 5'd9;
        cyc(v, S_HAZ, F_HAZ, 1'b0);
        // Branch on an ALU result in E; same without branch is no stall
        v = z; v.branch = 1; v.rs = 5'd3; v.use_rs = 1; v.reg_writeE = 1; v.write_regE = 5'd3;
        cyc(v, S_HAZ, F_HAZ, 1'b0);
        v.branch = 0;
        cyc(v, S_NONE, F_NONE, 1'b0);
        // Memory stall outranks a hazard
        v = z; v.i_stall = 1; v.mem_readE = 1; v.reg_writeE = 1; v.write_regE = 5'd8;
        v.rs = 5'd8; v.use_rs = 1;
        cyc(v, S_ALL, F_NONE, 1'b0);
        cyc(z, S_NONE, F_NONE, 1'b0);

        // Divide: 5 stall cycles, counter ends at 5
        do_reset();
        v = z; v.div_start = 1;
        cyc(v, S_DIV, F_DIV, 1'b0);
        for (int i = 0; i < 4; i++) cyc(z, S_DIV, F_DIV, 1'b0);
        v = z; v.div_ready = 1;
        cyc(v, S_NONE, F_NONE, 1'b0);
        cyc(z, S_NONE, F_NONE, 1'b0);

        // One-cycle divide
        v = z; v.div_start = 1; v.div_ready = 1;
        cyc(v, S_NONE, F_NONE, 1'b0);
        cyc(z, S_NONE, F_NONE, 1'b0);

        // Exception in DIV_WAIT cycle 2
        v = z; v.div_start = 1;
        cyc(v, S_DIV, F_DIV, 1'b0);
        cyc(z, S_DIV, F_DIV, 1'b0);
        v = z; v.exc = 1;
        cyc(v, S_NONE, F_ALL, 1'b1);
        cyc(z, S_NONE, F_NONE, 1'b0);

        // Exception under a 3-cycle d_stall
        v = z; v.exc = 1; v.d_stall = 1;
        cyc(v, S_ALL, F_NONE, 1'b0);
        v = z; v.d_stall = 1;
        cyc(v, S_ALL, F_NONE, 1'b0);
        cyc(v, S_ALL, F_NONE, 1'b0);
        cyc(z, S_NONE, F_ALL, 1'b0);
        cyc(z, S_NONE, F_NONE, 1'b0);

        // Immediate exception outranks a hazard
        v = z; v.exc = 1; v.branch = 1; v.rs = 5'd4; v.use_rs = 1;
        v.reg_writeE = 1; v.write_regE = 5'd4;
        cyc(v, S_NONE, F_ALL, 1'b0);
        cyc(z, S_NONE, F_NONE, 1'b0);

        // Reset while in EXC_HOLD
        v = z; v.exc = 1; v.d_stall = 1;
        cyc(v, S_ALL, F_NONE, 1'b0);
        v = z; v.d_stall = 1;
        cyc(v, S_ALL, F_NONE, 1'b0);
        do_reset();
        cyc(z, S_NONE, F_NONE, 1'b0);

        // Counter saturation with continuous i_stall
        v = z; v.i_stall = 1;
        for (int i = 0; i < 20; i++) cyc(v, S_ALL, F_NONE, 1'b0);
        cyc(z, S_NONE, F_NONE, 1'b0);
        cyc(z, S_NONE, F_NONE, 1'b0);
        do_reset();
        cyc(z, S_NONE, F_NONE, 1'b0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk); guard++;
        end
        if (exp_q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
